// File: rtl/digit_scan_seq.sv
// Multiplexed display digit scanner: dwell counter, digit index, latch strobe, frame/RTC sync pulses.
// Define DIGIT_SCAN_ONEHOT_EN to add the blankable one-hot digit_oh output.
module digit_scan_seq #(
   parameter int NUM_DIGITS = 6,
   parameter int DWELL      = 12,
   parameter int SEL_W      = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  tick,
   input  logic                  rtc_tick,
`ifdef DIGIT_SCAN_ONEHOT_EN
   input  logic                  blank,
   output logic [NUM_DIGITS-1:0] digit_oh,
`endif
   output logic [SEL_W-1:0]      sel,
   output logic                  latch,
   output logic                  frame_done,
   output logic                  sync_rst
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [SEL_W-1:0] r_idx;
   logic             r_frameDone;
   logic             r_syncRst;

   logic w_adv;
   logic w_cntWrap;
   logic w_idxWrap;

   // Coincident tick and rtc_tick count as a single event; >= makes out-of-range values recover.
   assign w_adv     = en & (tick | rtc_tick);
   assign w_cntWrap = (r_cnt >= CNT_LAST);
   assign w_idxWrap = (r_idx >= IDX_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_frameDone <= 1'b0;
         r_syncRst   <= 1'b0;
      end else begin
         r_frameDone <= w_adv & w_cntWrap & w_idxWrap;
         r_syncRst   <= en & rtc_tick & (r_idx == IDX_LAST) & (r_cnt == CNT_LAST);
         if (w_adv) begin
            if (w_cntWrap) begin
               r_cnt <= '0;
               r_idx <= w_idxWrap ? '0 : r_idx + SEL_W'(1);
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign sel        = r_idx;
   assign latch      = (r_cnt == CNT_W'(1));
   assign frame_done = r_frameDone;
   assign sync_rst   = r_syncRst;

`ifdef DIGIT_SCAN_ONEHOT_EN
   always_comb begin
      digit_oh = '0;
      if (!blank) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == SEL_W'(i)) digit_oh[i] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_digit_scan_seq.sv
// Self-checking bench for digit_scan_seq (6 digits, dwell 12) using an expected-output queue.
module tb_digit_scan_seq;

   typedef struct packed {
      logic [2:0] sel;
      logic       latch;
      logic       fd;
      logic       sr;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       tick = 1'b0;
   logic       rtc_tick = 1'b0;
   logic [2:0] sel;
   logic       latch;
   logic       frame_done;
   logic       sync_rst;
`ifdef DIGIT_SCAN_ONEHOT_EN
   logic       blank = 1'b0;
   logic [5:0] digit_oh;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];
   int   mCnt = 0;
   int   mIdx = 0;

   digit_scan_seq #(.NUM_DIGITS(6), .DWELL(12), .SEL_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .tick       (tick),
      .rtc_tick   (rtc_tick),
`ifdef DIGIT_SCAN_ONEHOT_EN
      .blank      (blank),
      .digit_oh   (digit_oh),
`endif
      .sel        (sel),
      .latch      (latch),
      .frame_done (frame_done),
      .sync_rst   (sync_rst)
   );

   always #5 clk = ~clk;

   // One clock with the given inputs; the behavioural model's expectation is queued for the caller.
   task automatic drive(input logic t, input logic r, input logic e);
      logic adv, fdN, srN;
      exp_t x;
      tick = t; rtc_tick = r; en = e;
      @(posedge clk);
      adv = e & (t | r);
      fdN = adv && (mCnt == 11) && (mIdx == 5);
      srN = e && r && (mIdx == 5) && (mCnt == 11);
      if (adv) begin
         if (mCnt == 11) begin
            mCnt = 0;
            mIdx = (mIdx == 5) ? 0 : mIdx + 1;
         end else begin
            mCnt = mCnt + 1;
         end
      end
      x.sel = 3'(mIdx); x.latch = (mCnt == 1); x.fd = fdN; x.sr = srN;
      expQ.push_back(x);
      #1;
      tick = 1'b0; rtc_tick = 1'b0;
   endtask

   task automatic doReset();
      @(posedge clk); #2;
      reset = 1'b1; en = 1'b0; tick = 1'b0; rtc_tick = 1'b0;
      #10;
      reset = 1'b0;
      mCnt = 0; mIdx = 0;
      expQ.delete();
   endtask

   task automatic test_reset();
      exp_t e;
      doReset();
      checks++;
      if ({sel, latch, frame_done, sync_rst} !== 6'b000_0_0_0) begin
         errors++;
         $display("[TB] FAIL reset_values: got %b, want %b", {sel, latch, frame_done, sync_rst}, 6'b0);
      end
`ifdef DIGIT_SCAN_ONEHOT_EN
      checks++;
      if (digit_oh !== 6'b000001) begin
         errors++;
         $display("[TB] FAIL reset_onehot: got %b, want 000001", digit_oh);
      end
`endif
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b0, 1'b1);
         e = expQ.pop_front();
         checks++;
         if ({sel, latch, frame_done, sync_rst} !== e) begin
            errors++;
            $display("[TB] FAIL reset_idle[%0d]: got %b, want %b", i, {sel, latch, frame_done, sync_rst}, e);
         end
      end
   endtask

   task automatic test_dwell();
      exp_t e;
      logic [3:0] want;
      doReset();
      for (int n = 1; n <= 13; n++) begin
         drive(1'b1, 1'b0, 1'b1);
         e = expQ.pop_front();
         checks++;
         if ({sel, latch, frame_done, sync_rst} !== e) begin
            errors++;
            $display("[TB] FAIL dwell_tick%0d: got %b, want %b", n, {sel, latch, frame_done, sync_rst}, e);
         end
         drive(1'b0, 1'b0, 1'b1);
         e = expQ.pop_front();
         want = (n == 1 || n == 13) ? {3'(n / 12), 1'b1} : {3'(n / 12), 1'b0};
         checks++;
         if ({sel, latch} !== want || {sel, latch, frame_done, sync_rst} !== e) begin
            errors++;
            $display("[TB] FAIL dwell_hold%0d: got sel/latch %b, want %b", n, {sel, latch}, want);
         end
      end
   endtask

   task automatic test_full_frame();
      exp_t e;
      int fdCount = 0;
      int fdAtTick = -1;
      doReset();
      for (int n = 1; n <= 72; n++) begin
         for (int k = 0; k < 3; k++) begin
            drive(k == 0, 1'b0, 1'b1);
            e = expQ.pop_front();
            if (frame_done === 1'b1) begin
               fdCount++;
               if (k == 0) fdAtTick = n;
            end
            checks++;
            if ({sel, latch, frame_done, sync_rst} !== e) begin
               errors++;
               $display("[TB] FAIL frame_t%0d_c%0d: got %b, want %b", n, k, {sel, latch, frame_done, sync_rst}, e);
            end
         end
      end
      checks++;
      if (fdCount != 1 || fdAtTick != 72 || sel !== 3'd0) begin
         errors++;
         $display("[TB] FAIL frame_done_once: got count %0d at tick %0d sel %0d, want 1 at 72 sel 0",
                  fdCount, fdAtTick, sel);
      end
   endtask

   task automatic test_rtc_sync();
      exp_t e;
      logic [5:0] want [3];
      want[0] = {3'd0, 1'b0, 1'b1, 1'b1};
      want[1] = {3'd5, 1'b0, 1'b0, 1'b0};
      want[2] = {3'd0, 1'b0, 1'b1, 1'b0};
      for (int s = 0; s < 3; s++) begin
         doReset();
         for (int n = 0; n < ((s == 1) ? 59 : 71); n++) begin
            drive(1'b1, 1'b0, 1'b1);
            e = expQ.pop_front();
            checks++;
            if ({sel, latch, frame_done, sync_rst} !== e) begin
               errors++;
               $display("[TB] FAIL rtc_setup%0d_%0d: got %b, want %b", s, n, {sel, latch, frame_done, sync_rst}, e);
            end
         end
         drive(s == 2, s != 2, 1'b1);
         e = expQ.pop_front();
         checks++;
         if ({sel, latch, frame_done, sync_rst} !== want[s] || {sel, latch, frame_done, sync_rst} !== e) begin
            errors++;
            $display("[TB] FAIL rtc_case%0d: got %b, want %b", s, {sel, latch, frame_done, sync_rst}, want[s]);
         end
         drive(1'b0, 1'b0, 1'b1);
         e = expQ.pop_front();
         checks++;
         if ({sel, latch, frame_done, sync_rst} !== e || sync_rst !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rtc_pulse_end%0d: got %b, want %b", s, {sel, latch, frame_done, sync_rst}, e);
         end
      end
   endtask

   task automatic test_coincident_hold();
      exp_t e;
      doReset();
      drive(1'b1, 1'b1, 1'b1);
      e = expQ.pop_front();
      checks++;
      if ({sel, latch, frame_done, sync_rst} !== e || latch !== 1'b1) begin
         errors++;
         $display("[TB] FAIL coincident: got %b, want %b", {sel, latch, frame_done, sync_rst}, e);
      end
      for (int i = 0; i < 30; i++) begin
         drive(i % 2 == 0, i % 3 == 0, 1'b0);
         e = expQ.pop_front();
         checks++;
         if ({sel, latch} !== 4'b000_1 || {sel, latch, frame_done, sync_rst} !== e) begin
            errors++;
            $display("[TB] FAIL en_hold[%0d]: got %b, want %b", i, {sel, latch, frame_done, sync_rst}, e);
         end
      end
      for (int i = 0; i < 70; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         e = expQ.pop_front();
      end
      drive(1'b0, 1'b1, 1'b1);
      e = expQ.pop_front();
      checks++;
      if ({sel, latch, frame_done, sync_rst} !== e || sync_rst !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pulse_before_hold: got %b, want %b", {sel, latch, frame_done, sync_rst}, e);
      end
      drive(1'b1, 1'b1, 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({sel, latch, frame_done, sync_rst} !== 6'b000_0_0_0 || {sel, latch, frame_done, sync_rst} !== e) begin
         errors++;
         $display("[TB] FAIL pulse_drop_en0: got %b, want 000000", {sel, latch, frame_done, sync_rst});
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      doReset();
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         e = expQ.pop_front();
      end
      checks++;
      if (sel !== 3'd3) begin
         errors++;
         $display("[TB] FAIL async_setup: got sel %0d, want 3", sel);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({sel, latch, frame_done, sync_rst} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %b, want 000000", {sel, latch, frame_done, sync_rst});
      end
      #1;
      reset = 1'b0;
      mCnt = 0; mIdx = 0;
      drive(1'b0, 1'b0, 1'b1);
      e = expQ.pop_front();
      checks++;
      if ({sel, latch, frame_done, sync_rst} !== e) begin
         errors++;
         $display("[TB] FAIL async_release: got %b, want %b", {sel, latch, frame_done, sync_rst}, e);
      end
   endtask

`ifdef DIGIT_SCAN_ONEHOT_EN
   task automatic test_onehot();
      exp_t e;
      doReset();
      for (int i = 0; i < 24; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         e = expQ.pop_front();
      end
      checks++;
      if (digit_oh !== 6'b000100 || sel !== 3'd2) begin
         errors++;
         $display("[TB] FAIL onehot_sel2: got %b, want 000100", digit_oh);
      end
      blank = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         e = expQ.pop_front();
         checks++;
         if (digit_oh !== 6'b0 || {sel, latch, frame_done, sync_rst} !== e) begin
            errors++;
            $display("[TB] FAIL onehot_blank[%0d]: got oh %b state %b, want 000000 %b",
                     i, digit_oh, {sel, latch, frame_done, sync_rst}, e);
         end
      end
      blank = 1'b0;
      #1;
      checks++;
      if (digit_oh !== 6'b001000) begin
         errors++;
         $display("[TB] FAIL onehot_unblank: got %b, want 001000", digit_oh);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_dwell();
      test_full_frame();
      test_rtc_sync();
      test_coincident_hold();
      test_async_reset();
`ifdef DIGIT_SCAN_ONEHOT_EN
      test_onehot();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no completion, want completion before 200000");
      $fatal(1, "[TB] timeout");
   end

endmodule
